// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard, pending-write counter and rs1/rs2 compare flag.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and post-edge busy) to the read ports.

module regfile_mp_rdport #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]              addr,
    input  logic [NREG-1:0][XLEN-1:0]  regs,
    input  logic [NREG-1:0]            busy,
    input  logic                       fwd_vld,
    input  logic [XLEN-1:0]            fwd_data,
    input  logic                       fwd_busy,
    output logic [XLEN-1:0]            data,
    output logic                       busy_o
);
    always_comb begin
        data   = '0;
        busy_o = 1'b0;
        if (addr != '0) begin
            if (fwd_vld) begin
                data   = fwd_data;
                busy_o = fwd_busy;
            end else begin
                data   = regs[addr];
                busy_o = busy[addr];
            end
        end
    end
endmodule

module regfile_mp #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    input  logic                 cmp_sign,
    output logic [2:0]           cmp_flag,
    output logic [AW:0]          pend_cnt,
    output logic [NREG*XLEN-1:0] reg_dump
);
    localparam int CW = AW + 1;

    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREG-1:0]           busy_q, busy_d;
    logic [CW-1:0]             pend_cnt_q, pend_cnt_d;

    logic [NWR-1:0][AW-1:0]    wa;
    logic [NWR-1:0][XLEN-1:0]  wd;
    logic [NRD-1:0][AW-1:0]    ra;
    logic [NRD-1:0][XLEN-1:0]  rd;
    logic [NRD-1:0]            fwd_vld;
    logic [NRD-1:0][XLEN-1:0]  fwd_data;
    logic [NRD-1:0]            fwd_busy;

    assign wa = wr_addr;
    assign wd = wr_data;
    assign ra = rd_addr;

    // Ports are applied in ascending order so the highest-index writer wins;
    // alloc is applied last so a same-cycle re-allocation keeps the bit set.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && wa[k] != '0) begin
                regs_d[wa[k]] = wd[k];
                busy_d[wa[k]] = 1'b0;
            end
        end
        if (alloc_en && alloc_addr != '0)
            busy_d[alloc_addr] = 1'b1;
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
        pend_cnt_d = '0;
        for (int i = 1; i < NREG; i++)
            pend_cnt_d = pend_cnt_d + CW'(busy_d[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '0;
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        fwd_vld  = '0;
        fwd_data = '0;
        fwd_busy = '0;
        for (int r = 0; r < NRD; r++) begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && wa[k] == ra[r] && ra[r] != '0) begin
                    fwd_vld[r]  = 1'b1;
                    fwd_data[r] = wd[k];
                end
            end
            fwd_busy[r] = alloc_en && (alloc_addr == ra[r]);
        end
    end
`else
    assign fwd_vld  = '0;
    assign fwd_data = '0;
    assign fwd_busy = '0;
`endif

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        regfile_mp_rdport #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rd (
            .addr     (ra[r]),
            .regs     (regs_q),
            .busy     (busy_q),
            .fwd_vld  (fwd_vld[r]),
            .fwd_data (fwd_data[r]),
            .fwd_busy (fwd_busy[r]),
            .data     (rd[r]),
            .busy_o   (rd_busy[r])
        );
    end

    always_comb begin
        cmp_flag = 3'd0;
        if (rd[0] != rd[1]) begin
            if (cmp_sign)
                cmp_flag = ($signed(rd[0]) > $signed(rd[1])) ? 3'd1 : 3'd3;
            else
                cmp_flag = (rd[0] > rd[1]) ? 3'd2 : 3'd4;
        end
    end

    assign rd_data  = rd;
    assign pend_cnt = pend_cnt_q;
    assign reg_dump = regs_q;
endmodule
